// File: rtl/trivium_seq_ctrl.sv
// Trivium sequencer: serial key collection, IV capture, core load, 1152-round
// warm-up, and byte-wise XOR encryption with a per-key byte budget.
module trivium_seq_ctrl #(
    parameter int KEY_W      = 80,
    parameter int INIT_STEPS = 144,
    parameter int MAX_BYTES  = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key,
    input  logic             strob_key,
    input  logic [KEY_W-1:0] iv,
    input  logic [7:0]       data,
    input  logic             strob_data,
    input  logic [7:0]       core_ks,
    output logic             core_load,
    output logic [KEY_W-1:0] core_key,
    output logic [KEY_W-1:0] core_iv,
    output logic             core_step,
    output logic [7:0]       stream,
    output logic             stream_vld,
    output logic             wt_sgn,
    output logic [7:0]       sign_reg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_KEY    = 3'd1,
        S_LOAD   = 3'd2,
        S_WARMUP = 3'd3,
        S_READY  = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    localparam logic [7:0] SG_OK    = 8'h00;
    localparam logic [7:0] SG_IDLE  = 8'h01;
    localparam logic [7:0] SG_KEY   = 8'h02;
    localparam logic [7:0] SG_WARM  = 8'h03;
    localparam logic [7:0] SG_REKEY = 8'h10;

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   key_reg, key_d;
    logic [KEY_W-1:0]   iv_reg, iv_d;
    logic [6:0]         key_cnt, key_cnt_d;
    logic [7:0]         init_cnt, init_cnt_d;
    logic [15:0]        byte_cnt, byte_cnt_d;
    logic [7:0]         stream_d, sign_d;
    logic               vld_d;
    logic [KEY_W-1:0]   key_shift;

    // New key bit enters at the top, so the first bit received ends in bit 0.
    assign key_shift = {key, key_reg[KEY_W-1:1]};
    assign core_key  = key_reg;
    assign core_iv   = iv_reg;

    // State and datapath registers; reset drops everything back to IDLE at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            key_reg    <= '0;
            iv_reg     <= '0;
            key_cnt    <= '0;
            init_cnt   <= '0;
            byte_cnt   <= '0;
            stream     <= '0;
            stream_vld <= 1'b0;
            sign_reg   <= '0;
        end else begin
            state_q    <= state_d;
            key_reg    <= key_d;
            iv_reg     <= iv_d;
            key_cnt    <= key_cnt_d;
            init_cnt   <= init_cnt_d;
            byte_cnt   <= byte_cnt_d;
            stream     <= stream_d;
            stream_vld <= vld_d;
            sign_reg   <= sign_d;
        end
    end

    // Next-state, next-datapath and core control strobes.
    always_comb begin
        state_d    = state_q;
        key_d      = key_reg;
        iv_d       = iv_reg;
        key_cnt_d  = key_cnt;
        init_cnt_d = init_cnt;
        byte_cnt_d = byte_cnt;
        stream_d   = stream;
        vld_d      = 1'b0;
        sign_d     = sign_reg;
        core_load  = 1'b0;
        core_step  = 1'b0;
        wt_sgn     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (strob_key) begin
                    key_d      = key_shift;
                    key_cnt_d  = 7'd1;
                    byte_cnt_d = '0;
                    sign_d     = SG_OK;
                    state_d    = S_KEY;
                end else if (strob_data || data != 8'd0) begin
                    sign_d  = SG_IDLE;
                    state_d = S_ERROR;
                end
            end
            S_KEY: begin
                wt_sgn = 1'b1;
                if (strob_data) begin
                    sign_d  = SG_KEY;
                    state_d = S_ERROR;
                end else if (strob_key) begin
                    key_d     = key_shift;
                    key_cnt_d = key_cnt + 7'd1;
                    if (key_cnt == 7'(KEY_W - 1)) begin
                        iv_d    = iv;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                wt_sgn     = 1'b1;
                core_load  = 1'b1;
                init_cnt_d = '0;
                state_d    = S_WARMUP;
            end
            S_WARMUP: begin
                wt_sgn    = 1'b1;
                core_step = 1'b1;
                if (strob_data) begin
                    sign_d  = SG_WARM;
                    state_d = S_ERROR;
                end else begin
                    init_cnt_d = init_cnt + 8'd1;
                    if (init_cnt == 8'(INIT_STEPS - 1))
                        state_d = S_READY;
                end
            end
            S_READY: begin
                if (strob_data) begin
                    core_step  = 1'b1;
                    stream_d   = data ^ core_ks;
                    vld_d      = 1'b1;
                    byte_cnt_d = byte_cnt + 16'd1;
                    if (byte_cnt == 16'(MAX_BYTES - 1)) begin
                        key_d   = '0;
                        sign_d  = SG_REKEY;
                        state_d = S_IDLE;
                    end
                end
                // Rekey overrides the budget exit; the byte above is still emitted.
                if (strob_key) begin
                    key_d      = key_shift;
                    key_cnt_d  = 7'd1;
                    byte_cnt_d = '0;
                    sign_d     = SG_OK;
                    state_d    = S_KEY;
                end
            end
            S_ERROR: begin
                key_d      = '0;
                iv_d       = '0;
                byte_cnt_d = '0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_trivium_seq_ctrl.sv
`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            errors++; \
            $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
        end \
    end

module tb_trivium_seq_ctrl;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_KEY   = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_READY = 3'd4;
    localparam logic [2:0] ST_ERROR = 3'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key = 1'b0;
    logic        strob_key = 1'b0;
    logic [79:0] iv = '0;
    logic [7:0]  data = '0;
    logic        strob_data = 1'b0;
    logic [7:0]  core_ks = '0;
    logic        core_load;
    logic [79:0] core_key;
    logic [79:0] core_iv;
    logic        core_step;
    logic [7:0]  stream;
    logic        stream_vld;
    logic        wt_sgn;
    logic [7:0]  sign_reg;

    int checks = 0;
    int errors = 0;

    logic [79:0] k1 = 80'hC3A5_1F2E_0D9B_7766_5544;
    logic [79:0] v1 = 80'h0123_4567_89AB_CDEF_F00D;
    logic [79:0] k2 = 80'h8000_0000_0000_0000_0001;
    logic [79:0] k3 = 80'h1234_5678_9ABC_DEF0_1357;

    logic [7:0]  exp_byte;

    trivium_seq_ctrl #(.KEY_W(80), .INIT_STEPS(144), .MAX_BYTES(4)) dut (
        .clk(clk), .rst(rst), .key(key), .strob_key(strob_key), .iv(iv),
        .data(data), .strob_data(strob_data), .core_ks(core_ks),
        .core_load(core_load), .core_key(core_key), .core_iv(core_iv),
        .core_step(core_step), .stream(stream), .stream_vld(stream_vld),
        .wt_sgn(wt_sgn), .sign_reg(sign_reg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [79:0] k, input logic [79:0] v,
                            input int first, input int last);
        for (int i = first; i < last; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            key = k[i];
            iv = v;
            strob_key = 1'b1;
            tick();
            strob_key = 1'b0;
            key = 1'b0;
            if (i < 79) `CHK("no_load_during_key", core_load, 1'b0)
        end
    endtask

    task automatic warmup(input logic [79:0] k, input logic [79:0] v);
        int steps;
        int loads;
        int n;
        `CHK("load_state", dut.state_q, ST_LOAD)
        `CHK("load_pulse", core_load, 1'b1)
        `CHK("load_key_val", core_key, k)
        `CHK("load_iv_val", core_iv, v)
        steps = 0;
        loads = 1;
        n = 0;
        tick();
        while (wt_sgn && n < 400) begin
            if (core_step) steps++;
            if (core_load) loads++;
            tick();
            n++;
        end
        `CHK("warm_steps", steps, 144)
        `CHK("load_once", loads, 1)
        `CHK("ready_on_wt_fall", dut.state_q, ST_READY)
        `CHK("ready_no_step", core_step, 1'b0)
    endtask

    initial begin
        #2;
        `CHK("rst_state", dut.state_q, ST_IDLE)
        `CHK("rst_sign", sign_reg, 8'h00)
        `CHK("rst_stream", stream, 8'h00)
        `CHK("rst_vld", stream_vld, 1'b0)
        `CHK("rst_wt", wt_sgn, 1'b0)
        `CHK("rst_key", core_key, 80'h0)
        `CHK("rst_load", core_load, 1'b0)
        tick();
        rst = 1'b0;
        tick();

        load_key(k1, v1, 0, 80);
        warmup(k1, v1);

        core_ks = 8'hA5;
        data = 8'h3C;
        strob_data = 1'b1;
        #1;
        `CHK("enc_step_same_cycle", core_step, 1'b1)
        `CHK("enc_vld_not_yet", stream_vld, 1'b0)
        tick();
        strob_data = 1'b0;
        data = 8'h00;
        `CHK("enc_stream", stream, 8'h99)
        `CHK("enc_vld", stream_vld, 1'b1)
        `CHK("enc_byte_cnt", dut.byte_cnt, 16'd1)
        tick();
        `CHK("enc_vld_pulse", stream_vld, 1'b0)
        `CHK("enc_stream_hold", stream, 8'h99)

        data = 8'h0F;
        strob_data = 1'b1;
        key = k2[0];
        strob_key = 1'b1;
        tick();
        strob_data = 1'b0;
        strob_key = 1'b0;
        data = 8'h00;
        `CHK("coin_stream", stream, 8'hAA)
        `CHK("coin_vld", stream_vld, 1'b1)
        `CHK("coin_state", dut.state_q, ST_KEY)
        `CHK("coin_key_cnt", dut.key_cnt, 7'd1)
        `CHK("coin_byte_cnt", dut.byte_cnt, 16'd0)
        `CHK("coin_wt", wt_sgn, 1'b1)
        load_key(k2, v1, 1, 80);
        warmup(k2, v1);

        core_ks = 8'h01;
        for (int i = 0; i < 5; i++) begin
            data = 8'h10 + 8'(i);
            strob_data = 1'b1;
            tick();
            if (i < 4) begin
                exp_byte = (8'h10 + 8'(i)) ^ 8'h01;
                checks++;
                if (stream_vld !== 1'b1) begin
                    errors++;
                    $error("FAIL bud_vld observed=%0h expected=1", stream_vld);
                end
                checks++;
                if (stream !== exp_byte) begin
                    errors++;
                    $error("FAIL bud_stream observed=%0h expected=%0h", stream, exp_byte);
                end
            end
            if (i == 3) begin
                `CHK("bud_idle", dut.state_q, ST_IDLE)
                `CHK("bud_sign_rekey", sign_reg, 8'h10)
                `CHK("bud_key_clear", core_key, 80'h0)
            end
            if (i == 4) begin
                `CHK("bud5_vld", stream_vld, 1'b0)
                `CHK("bud5_stream_hold", stream, 8'h12)
                `CHK("bud5_err", dut.state_q, ST_ERROR)
                `CHK("bud5_sign", sign_reg, 8'h01)
            end
        end
        strob_data = 1'b0;
        data = 8'h00;
        tick();
        `CHK("bud_back_idle", dut.state_q, ST_IDLE)
        `CHK("bud_sign_hold", sign_reg, 8'h01)

        load_key(k3, v1, 0, 80);
        `CHK("r_load", core_load, 1'b1)
        repeat (51) tick();
        `CHK("r_init_cnt", dut.init_cnt, 8'd50)
        `CHK("r_stepping", core_step, 1'b1)
        rst = 1'b1;
        #1;
        `CHK("r_state", dut.state_q, ST_IDLE)
        `CHK("r_wt", wt_sgn, 1'b0)
        `CHK("r_step", core_step, 1'b0)
        `CHK("r_sign", sign_reg, 8'h00)
        tick();
        rst = 1'b0;
        tick();

        data = 8'h01;
        tick();
        data = 8'h00;
        `CHK("idle_data_err", dut.state_q, ST_ERROR)
        `CHK("idle_data_sign", sign_reg, 8'h01)
        tick();
        `CHK("idle_data_back", dut.state_q, ST_IDLE)

        load_key(k1, v1, 0, 40);
        `CHK("key40_cnt", dut.key_cnt, 7'd40)
        `CHK("key40_sign_ok", sign_reg, 8'h00)
        strob_data = 1'b1;
        key = 1'b1;
        strob_key = 1'b1;
        tick();
        strob_data = 1'b0;
        strob_key = 1'b0;
        key = 1'b0;
        `CHK("key_data_err", dut.state_q, ST_ERROR)
        `CHK("key_data_sign", sign_reg, 8'h02)
        `CHK("key_data_cnt", dut.key_cnt, 7'd40)
        tick();
        `CHK("key_err_idle", dut.state_q, ST_IDLE)
        `CHK("key_err_clr", core_key, 80'h0)
        `CHK("key_err_sign_hold", sign_reg, 8'h02)

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
